// File: rtl/poly_dds_voice_mixer_if.sv
// rtl/poly_dds_voice_mixer_if.sv - key/phase-increment inputs and mixed-sample outputs of the voice mixer
interface poly_dds_voice_mixer_if #(
    parameter int N_KEYS  = 8,
    parameter int OUT_W   = 8,
    parameter int PHASE_W = 16
);
    logic [N_KEYS-1:0]           key;
    logic [N_KEYS*PHASE_W-1:0]   phase_inc;
    logic [OUT_W-1:0]            wave;
    logic                        wave_valid;
    logic [$clog2(N_KEYS+1)-1:0] active_cnt;

    modport master (output key, phase_inc, input wave, wave_valid, active_cnt);
    modport slave  (input key, phase_inc, output wave, wave_valid, active_cnt);
endinterface

// File: rtl/poly_dds_voice_mixer.sv
// rtl/poly_dds_voice_mixer.sv - polyphonic DDS triangle mixer, one voice scanned per clock
// Optional per-voice attack/release envelope enabled by defining PIANO_ENV_EN.
module poly_dds_voice_mixer #(
    parameter int N_KEYS       = 8,
    parameter int OUT_W        = 8,
    parameter int PHASE_W      = 16,
    parameter int SAMPLE_DIV   = 1024,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    poly_dds_voice_mixer_if.slave bus
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int CNT_W = $clog2(N_KEYS + 1);
    localparam int ACC_W = OUT_W + $clog2(N_KEYS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_div;
    logic [N_KEYS-1:0]  r_key_s;
    logic [IDX_W-1:0]   r_idx;
    logic [PHASE_W-1:0] r_phase [N_KEYS];
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_wave;
    logic               r_wave_valid;
    logic [CNT_W-1:0]   r_active_cnt;

    logic               w_tick;
    logic               w_last;
    logic               w_active;
    logic [PHASE_W-1:0] w_inc [N_KEYS];
    logic [PHASE_W-1:0] w_phase;
    logic [OUT_W-1:0]   w_idx_bits;
    logic [OUT_W-1:0]   w_tri;
    logic [OUT_W-1:0]   w_contrib;
    logic [7:0]         w_shift;
    logic [OUT_W-1:0]   w_wave_sh;

    assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_last = (r_idx == IDX_W'(N_KEYS - 1));

    for (genvar k = 0; k < N_KEYS; k++) begin : g_inc
        assign w_inc[k] = bus.phase_inc[k*PHASE_W +: PHASE_W];
    end

    // Triangle: top phase bit folds the ramp, the next OUT_W bits are the ramp itself
    assign w_phase    = r_phase[r_idx];
    assign w_idx_bits = w_phase[PHASE_W-2 -: OUT_W];
    assign w_tri      = w_phase[PHASE_W-1] ? ~w_idx_bits : w_idx_bits;

`ifdef PIANO_ENV_EN
    logic [7:0]       r_gain [N_KEYS];
    logic [7:0]       w_gain;
    logic [7:0]       w_gain_nxt;
    logic [8:0]       w_gain_up;
    logic [OUT_W+7:0] w_prod;

    assign w_gain    = r_gain[r_idx];
    assign w_gain_up = {1'b0, w_gain} + 9'(ATTACK_STEP);
    assign w_prod    = (OUT_W+8)'(w_tri) * (OUT_W+8)'(w_gain);
    assign w_contrib = OUT_W'(w_prod >> 8);
    assign w_active  = r_key_s[r_idx] | (w_gain != 8'h00);

    always_comb begin
        w_gain_nxt = w_gain;
        if (r_key_s[r_idx]) begin
            w_gain_nxt = w_gain_up[8] ? 8'hFF : w_gain_up[7:0];
        end else if (w_gain > 8'(RELEASE_STEP)) begin
            w_gain_nxt = w_gain - 8'(RELEASE_STEP);
        end else begin
            w_gain_nxt = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_KEYS; k++) begin
                r_gain[k] <= 8'h00;
            end
        end else if (r_state == S_SCAN) begin
            r_gain[r_idx] <= w_gain_nxt;
        end
    end
`else
    assign w_contrib = w_tri;
    assign w_active  = r_key_s[r_idx];
`endif

    // Normalise by the smallest power of two not below the voice count
    always_comb begin
        w_shift = 8'd0;
        for (int k = 0; k < CNT_W; k++) begin
            if ((1 << k) < int'(r_cnt)) begin
                w_shift = 8'(k + 1);
            end
        end
    end
    assign w_wave_sh = OUT_W'(r_acc >> w_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_key_s      <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_wave       <= '0;
            r_wave_valid <= 1'b0;
            r_active_cnt <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                r_phase[k] <= '0;
            end
        end else begin
            r_wave_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_key_s <= bus.key;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_active) begin
                        r_acc          <= r_acc + ACC_W'(w_contrib);
                        r_phase[r_idx] <= w_phase + w_inc[r_idx];
                        r_cnt          <= r_cnt + CNT_W'(1);
                    end else begin
                        r_phase[r_idx] <= '0;
                    end
                    if (w_last) begin
                        r_state <= S_NORM;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_NORM: begin
                    r_wave       <= (r_cnt == '0) ? '0 : w_wave_sh;
                    r_active_cnt <= r_cnt;
                    r_wave_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wave       = r_wave;
    assign bus.wave_valid = r_wave_valid;
    assign bus.active_cnt = r_active_cnt;
endmodule

// File: tb/tb_poly_dds_voice_mixer.sv
// tb/tb_poly_dds_voice_mixer.sv - scoreboard bench for poly_dds_voice_mixer
`timescale 1ns/1ps
module tb_poly_dds_voice_mixer;
    localparam int N_KEYS     = 8;
    localparam int OUT_W      = 8;
    localparam int PHASE_W    = 16;
    localparam int SAMPLE_DIV = 16;
    localparam int LATENCY    = SAMPLE_DIV + N_KEYS + 1;

    typedef struct {
        int wave;
        int cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    poly_dds_voice_mixer_if #(.N_KEYS(N_KEYS), .OUT_W(OUT_W), .PHASE_W(PHASE_W)) bus ();

    poly_dds_voice_mixer #(
        .N_KEYS(N_KEYS), .OUT_W(OUT_W), .PHASE_W(PHASE_W),
        .SAMPLE_DIV(SAMPLE_DIV), .ATTACK_STEP(16), .RELEASE_STEP(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int edge_cnt   = 0;
    int valid_edge = 0;

    logic [PHASE_W-1:0]        m_phase [N_KEYS];
    int                        m_gain  [N_KEYS];
    logic [N_KEYS*PHASE_W-1:0] inc_v;
    exp_t                      sb [$];

    // Posedges since the last reset release; used to measure pulse timing
    always @(posedge clk) edge_cnt <= rst_n ? edge_cnt + 1 : 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_KEYS; i++) begin
            m_phase[i] = '0;
            m_gain[i]  = 0;
        end
        sb.delete();
    endtask

    task automatic set_inc(input int v, input logic [PHASE_W-1:0] val);
        inc_v[v*PHASE_W +: PHASE_W] = val;
    endtask

    task automatic push_expected(input logic [N_KEYS-1:0] k);
        int   acc, cnt, s, idx, tv;
        logic act;
        exp_t e;
`ifdef PIANO_ENV_EN
        int   g;
`endif
        acc = 0;
        cnt = 0;
        s   = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            idx = int'(m_phase[i][PHASE_W-2 -: OUT_W]);
            tv  = m_phase[i][PHASE_W-1] ? ((1 << OUT_W) - 1 - idx) : idx;
`ifdef PIANO_ENV_EN
            g   = m_gain[i];
            act = k[i] || (g > 0);
            if (act) acc += (tv * g) >> 8;
            m_gain[i] = k[i] ? ((g + 16 > 255) ? 255 : g + 16) : ((g - 4 < 0) ? 0 : g - 4);
`else
            act = k[i];
            if (act) acc += tv;
`endif
            if (act) begin
                cnt++;
                m_phase[i] = m_phase[i] + inc_v[i*PHASE_W +: PHASE_W];
            end else begin
                m_phase[i] = '0;
            end
        end
        while ((1 << s) < cnt) s++;
        e.wave = (cnt == 0) ? 0 : ((acc >> s) & ((1 << OUT_W) - 1));
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3 * SAMPLE_DIV; n++) begin
            @(negedge clk);
            if (bus.wave_valid) begin
                ok         = 1'b1;
                valid_edge = edge_cnt;
                break;
            end
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic run_sample(input logic [N_KEYS-1:0] k, output int w, output int c);
        bit   ok;
        exp_t e;
        bus.key       = k;
        bus.phase_inc = inc_v;
        push_expected(k);
        wait_valid(ok);
        w = int'(bus.wave);
        c = int'(bus.active_cnt);
        e = sb.pop_front();
        if (ok) begin
            check("sb_wave", w, e.wave);
            check("sb_cnt", c, e.cnt);
            @(negedge clk);
            check("valid_pulse_width", int'(bus.wave_valid), 0);
        end
    endtask

    initial begin
        int w, c, prev_edge;
        inc_v         = '0;
        bus.key       = '0;
        bus.phase_inc = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_wave", int'(bus.wave), 0);
        check("rst_valid", int'(bus.wave_valid), 0);
        check("rst_cnt", int'(bus.active_cnt), 0);
        rst_n = 1'b1;

        // Idle keyboard: silent samples at a fixed cadence
        prev_edge = 0;
        for (int s = 0; s < 3; s++) begin
            run_sample('0, w, c);
            check("t1_wave", w, 0);
            check("t1_cnt", c, 0);
            if (s == 0) check("t1_first_latency", valid_edge, LATENCY);
            else        check("t1_period", valid_edge - prev_edge, SAMPLE_DIV);
            prev_edge = valid_edge;
        end

        // Single voice through the triangle peak
        set_inc(0, 16'h0100);
        for (int s = 0; s < 131; s++) begin
            run_sample(8'h01, w, c);
`ifndef PIANO_ENV_EN
            if (s < 4)    check("t2_rise", w, 2 * s);
            if (s == 0)   check("t2_cnt", c, 1);
            if (s == 128) check("t2_peak", w, 255);
            if (s == 129) check("t2_fall", w, 253);
`endif
        end

        // Two voices in unison
        run_sample('0, w, c);
        set_inc(1, 16'h0100);
        for (int s = 0; s < 4; s++) begin
            run_sample(8'h03, w, c);
`ifndef PIANO_ENV_EN
            check("t3_wave", w, 2 * s);
            check("t3_cnt", c, 2);
`endif
        end

        // Three voices: non-power-of-two count rounds the shift up
        run_sample('0, w, c);
        set_inc(2, 16'h0100);
        for (int s = 0; s < 4; s++) begin
            run_sample(8'h07, w, c);
`ifndef PIANO_ENV_EN
            if (s == 3) check("t4_wave", w, 4);
            check("t4_cnt", c, 3);
`endif
        end

        // Release and re-press restarts the note at phase 0
        run_sample('0, w, c);
        for (int s = 0; s < 5; s++) run_sample(8'h01, w, c);
        run_sample('0, w, c);
`ifndef PIANO_ENV_EN
        check("t5_gap_wave", w, 0);
        check("t5_gap_cnt", c, 0);
`endif
        run_sample(8'h01, w, c);
`ifndef PIANO_ENV_EN
        check("t5_restart0", w, 0);
`endif
        run_sample(8'h01, w, c);
`ifndef PIANO_ENV_EN
        check("t5_restart1", w, 2);
`endif
        run_sample(8'h01, w, c);

        // Reset in the middle of a scan
        for (int n = 0; n < 4 * SAMPLE_DIV; n++) begin
            if (edge_cnt % SAMPLE_DIV == 2) break;
            @(negedge clk);
        end
`ifndef PIANO_ENV_EN
        check("t6_pre_wave", int'(bus.wave), 4);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_wave", int'(bus.wave), 0);
        check("t6_async_valid", int'(bus.wave_valid), 0);
        check("t6_async_cnt", int'(bus.active_cnt), 0);
        repeat (3) @(negedge clk);
        model_reset();
        bus.key = 8'h01;
        rst_n   = 1'b1;
        run_sample(8'h01, w, c);
        check("t6_latency_after_abort", valid_edge, LATENCY);
        check("t6_wave", w, 0);
        run_sample(8'h01, w, c);

`ifdef PIANO_ENV_EN
        // Envelope: constant phase 0x4000 gives tri=128, gain ramps by 16
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        inc_v = '0;
        set_inc(0, 16'h4000);
        bus.key       = 8'h01;
        bus.phase_inc = inc_v;
        rst_n = 1'b1;
        run_sample(8'h01, w, c);
        check("env_first", w, 0);
        set_inc(0, 16'h0000);
        for (int s = 1; s < 5; s++) begin
            run_sample(8'h01, w, c);
            check("env_ramp", w, 8 * s);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
